rr_sel_arbiter: RTL and testbench

//  Round-robin controller for an N_REQ:1 select-mux datapath (sel -> y). Shares
//  the mux between N_REQ requesters, holds each grant for up to MAX_HOLD cycles
//  and drives the mux select. Output data is registered. Sits in front of the

---
 rtl/rr_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 30 +++
 rtl/rr_sel_arbiter.sv | 77 +++++++
 tb/tb_rr_sel_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state type, default parameters and a one-hot decode helper
package rr_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int MAX_HOLD_DEF = 4;
  localparam int OH_W = 64;
  function automatic int unsigned onehot2bin(input logic [OH_W-1:0] oh);
    int unsigned b;
    b = 0;
    for (int i = 0; i < OH_W; i++) if (oh[i]) b |= unsigned'(i);
    return b;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search starting one past last_ptr
//   req      in  N_REQ  request vector
//   last_ptr in  SW     index of the previous winner
//   winner   out SW     first requester found scanning last_ptr+1 .. last_ptr
//   any_req  out 1      at least one request is set
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int SW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SW-1:0]    last_ptr,
  output logic [SW-1:0]    winner,
  output logic             any_req
);
  logic [SW-1:0] idx;
  // N_REQ is a power of two, so SW-bit addition wraps mod N_REQ and the final
  // step (i == N_REQ) lands on last_ptr itself: the previous winner comes last.
  always_comb begin
    winner = '0;
    any_req = 1'b0;
    idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last_ptr + SW'(i);
      if (!any_req && req[idx]) begin
        winner = idx;
        any_req = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin grant controller driving a registered N_REQ:1 mux
//   clk, rst_n  clock, asynchronous active-low reset
//   req         level-sensitive requests; din packs N_REQ words of DW bits
//   gnt, sel    registered one-hot grant and its binary index
//   y, y_valid  registered mux output and its qualifier
//   busy        high while a grant is held
module rr_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  localparam int SW = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    gnt,
  output logic [SW-1:0]       sel,
  output logic [DW-1:0]       y,
  output logic                y_valid,
  output logic                busy
);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  arb_state_e state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] last_ptr, win;
  logic any_req, rel;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(req),
    .last_ptr(last_ptr),
    .winner(win),
    .any_req(any_req)
  );
  // last_ptr equals sel while granting, so the holder is only re-picked when it
  // is the sole requester; a drop coinciding with the hold limit is one release.
  assign rel = !req[sel] || hold_cnt == HW'(MAX_HOLD - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_cnt <= '0;
      last_ptr <= SW'(N_REQ - 1);
      gnt <= '0;
      sel <= '0;
      y <= '0;
      y_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      y_valid <= |gnt;
      if (|gnt) y <= din[sel*DW +: DW];
      if (state == IDLE || rel) begin
        if (any_req) begin
          state <= GRANT;
          busy <= 1'b1;
          gnt <= N_REQ'(1) << win;
          sel <= win;
          last_ptr <= win;
          hold_cnt <= '0;
        end else begin
          state <= IDLE;
          busy <= 1'b0;
          gnt <= '0;
          hold_cnt <= '0;
        end
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(req));
      if (|gnt) assert ($onehot(gnt) && onehot2bin(OH_W'(gnt)) == 32'(sel));
    end
  end
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed and random checks of rr_sel_arbiter against a grant-history model
module tb_rr_sel_arbiter;
  localparam int N = 4, DW = 8, MH = 4, SW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*DW-1:0] din = '0;
  logic [N-1:0] gnt;
  logic [SW-1:0] sel;
  logic [DW-1:0] y;
  logic y_valid, busy;
  int tests = 0, fails = 0;
  int m_cur, m_held, m_last, m_sel;
  logic [DW-1:0] m_y;
  logic m_yv;
  logic [N*DW-1:0] dpat = {8'h44, 8'haa, 8'h22, 8'h11};

  rr_sel_arbiter #(.N_REQ(N), .DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic m_reset();
    m_cur = -1; m_held = 0; m_last = N - 1; m_sel = 0; m_y = '0; m_yv = 1'b0;
  endtask

  // One clock edge of the model: the current holder is kept until it stops
  // requesting or has held for MH cycles; then the rotating search decides.
  task automatic m_step(input logic [N-1:0] r, input logic [N*DW-1:0] d);
    int w;
    if (m_cur >= 0) begin m_y = d[m_cur*DW +: DW]; m_yv = 1'b1; end
    else m_yv = 1'b0;
    if (m_cur < 0 || !r[m_cur] || m_held == MH) begin
      w = pick(r, m_last);
      if (w >= 0) begin m_cur = w; m_sel = w; m_last = w; m_held = 1; end
      else begin m_cur = -1; m_held = 0; end
    end else m_held++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("gnt", 64'(gnt), m_cur >= 0 ? (64'd1 << m_cur) : 64'd0);
    chk("sel", 64'(sel), 64'(m_sel));
    chk("y", 64'(y), 64'(m_y));
    chk("y_valid", 64'(y_valid), 64'(m_yv));
    chk("busy", 64'(busy), 64'(m_cur >= 0));
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N*DW-1:0] d);
    req = r; din = d;
    m_step(r, d);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    m_reset();
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_yv", 64'(y_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    // single requester from IDLE
    cyc(4'b0100, dpat);
    chk("t1_gnt", 64'(gnt), 64'h4);
    chk("t1_sel", 64'(sel), 64'd2);
    cyc(4'b0100, dpat);
    chk("t1_y", 64'(y), 64'haa);
    chk("t1_yv", 64'(y_valid), 64'd1);
    cyc(4'b0000, dpat);
    cyc(4'b0000, dpat);
    // full load: each requester for exactly MH cycles, in order
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(4'b1111, dpat);
      chk("t2_rot", 64'(gnt), 64'd1 << ((c / 4) % 4));
    end
    // holder drops early, next requester takes over without a bubble
    do_reset();
    cyc(4'b0011, dpat); chk("t3_g0a", 64'(gnt), 64'h1);
    cyc(4'b0011, dpat); chk("t3_g0b", 64'(gnt), 64'h1);
    cyc(4'b0010, dpat); chk("t3_g1", 64'(gnt), 64'h2);
    // sole requester is re-granted past the hold limit
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc(4'b0010, dpat);
      chk("t4_hold", 64'(gnt), 64'h2);
    end
    // all requests drop
    cyc(4'b0000, dpat);
    chk("t5_gnt", 64'(gnt), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_yv1", 64'(y_valid), 64'd1);
    chk("t5_y1", 64'(y), 64'h22);
    cyc(4'b0000, dpat);
    chk("t5_yv0", 64'(y_valid), 64'd0);
    chk("t5_y0", 64'(y), 64'h22);
    // asynchronous reset while granting
    cyc(4'b1111, dpat); cyc(4'b1111, dpat); cyc(4'b1111, dpat);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_gnt", 64'(gnt), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_y", 64'(y), 64'd0);
    chk("t6_yv", 64'(y_valid), 64'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b1111, dpat);
    chk("t6_first", 64'(gnt), 64'h1);
    // random traffic against the model
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      cyc(r, (N*DW)'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
